// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed when the operation is launched and committed after a fixed latency.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} stateT;

  stateT          state, stateNext;
  logic [CW-1:0]  cnt, cntNext;
  logic [31:0]    phi, phiNext, plo, ploNext, hiNext, loNext;
  logic           pdz, pdzNext;

  logic [63:0]    prodS, prodU;
  logic [31:0]    aMag, bMag, qMag, rMag, resHi, resLo;
  logic           isSDiv;

  // Signed divide works on magnitudes so the most-negative / -1 case cannot overflow.
  always_comb begin
    isSDiv = (MDUOp == OP_DIV);
    prodS  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prodU  = {32'd0, a} * {32'd0, b};
    aMag   = (isSDiv && a[31]) ? (~a + 32'd1) : a;
    bMag   = (isSDiv && b[31]) ? (~b + 32'd1) : b;
    qMag   = (bMag == 32'd0) ? 32'd0 : aMag / bMag;
    rMag   = (bMag == 32'd0) ? 32'd0 : aMag % bMag;
    resHi  = 32'd0;
    resLo  = 32'd0;
    case (MDUOp)
      OP_MULT:  {resHi, resLo} = prodS;
      OP_MULTU: {resHi, resLo} = prodU;
      OP_DIV: begin
        resLo = (a[31] ^ b[31]) ? (~qMag + 32'd1) : qMag;
        resHi = a[31] ? (~rMag + 32'd1) : rMag;
      end
      OP_DIVU: begin
        resLo = qMag;
        resHi = rMag;
      end
      default: ;
    endcase
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    phiNext   = phi;
    ploNext   = plo;
    pdzNext   = pdz;
    hiNext    = HI;
    loNext    = LO;
    case (state)
      IDLE: begin
        if (start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU)) begin
          phiNext   = resHi;
          ploNext   = resLo;
          pdzNext   = (MDUOp >= OP_DIV) && (b == 32'd0);
          cntNext   = (MDUOp >= OP_DIV) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          stateNext = RUN;
        end else if (MDUOp == OP_MTHI) begin
          hiNext = a;
        end else if (MDUOp == OP_MTLO) begin
          loNext = a;
        end
      end
      RUN: begin
        cntNext = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          stateNext = IDLE;
          // A divide by zero still burns its cycles but leaves HI/LO untouched.
          if (!pdz) begin
            hiNext = phi;
            loNext = plo;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      phi   <= '0;
      plo   <= '0;
      pdz   <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      phi   <= phiNext;
      plo   <= ploNext;
      pdz   <= pdzNext;
      HI    <= hiNext;
      LO    <= loNext;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized operations
// compared against a plain-arithmetic HI/LO reference model.
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  logic [31:0] modelHi, modelLo;
  int          assertCount = 0;
  int          failCount   = 0;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .MDUOp(MDUOp),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Architectural effect of a launched op, from the instruction-set definition.
  task automatic modelOp(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    logic [63:0] p;
    longint q, r;
    sx = x;
    sy = y;
    case (op)
      3'd1: begin p = longint'(sx) * longint'(sy); modelHi = p[63:32]; modelLo = p[31:0]; end
      3'd2: begin p = {32'd0, x} * {32'd0, y}; modelHi = p[63:32]; modelLo = p[31:0]; end
      3'd3: if (y != 0) begin
        q = longint'(sx) / longint'(sy);
        r = longint'(sx) % longint'(sy);
        modelLo = q[31:0];
        modelHi = r[31:0];
      end
      3'd4: if (y != 0) begin
        modelLo = x / y;
        modelHi = x % y;
      end
      default: ;
    endcase
  endtask

  // Called at a negedge with idle inputs; returns at the negedge of cycle N+1.
  // mode 0: quiet while busy, 1: random junk on inputs, 2: DIV start + MTHI collision.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int mode);
    int n;
    n = (op >= 3'd3) ? DIV_N : MULT_N;
    a = x; b = y; MDUOp = op; start = 1'b1;
    checkOutput("busy_cycle0", busy, 1'b0);
    modelOp(op, x, y);
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
    for (int i = 1; i <= n; i++) begin
      checkOutput($sformatf("busy_cycle%0d", i), busy, 1'b1);
      if (mode == 1) begin
        start = 1'($urandom_range(0, 1));
        MDUOp = 3'($urandom_range(0, 7));
        a = $urandom; b = $urandom;
      end else if (mode == 2 && i == 2) begin
        start = 1'b1; MDUOp = 3'd3; a = 32'd100; b = 32'd7;
      end else if (mode == 2 && i == 3) begin
        start = 1'b0; MDUOp = 3'd5; a = 32'hAAAA;
      end else begin
        start = 1'b0; MDUOp = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; MDUOp = 3'd0;
    checkOutput("busy_done", busy, 1'b0);
    checkOutput("hi_result", HI, modelHi);
    checkOutput("lo_result", LO, modelLo);
  endtask

  task automatic writeHiLo(input logic [2:0] op, input logic [31:0] val);
    a = val; b = $urandom; MDUOp = op; start = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
    if (op == 3'd5) modelHi = val; else modelLo = val;
    checkOutput("mt_busy", busy, 1'b0);
    checkOutput("mt_hi", HI, modelHi);
    checkOutput("mt_lo", LO, modelLo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] x, y;
    reset = 1'b0; a = '0; b = '0; MDUOp = 3'd0; start = 1'b0;
    modelHi = '0; modelLo = '0;
    #2;
    checkOutput("reset_hi", HI, 32'd0);
    checkOutput("reset_lo", LO, 32'd0);
    checkOutput("reset_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(3'd1, 32'hFFFFFFFE, 32'd3, 0);
    checkOutput("mult_hi_const", HI, 32'hFFFFFFFF);
    checkOutput("mult_lo_const", LO, 32'hFFFFFFFA);
    applyStimulus(3'd2, 32'hFFFFFFFE, 32'd3, 0);
    checkOutput("multu_hi_const", HI, 32'h00000002);
    checkOutput("multu_lo_const", LO, 32'hFFFFFFFA);
    applyStimulus(3'd3, 32'hFFFFFFF9, 32'd2, 0);
    checkOutput("div_lo_const", LO, 32'hFFFFFFFD);
    checkOutput("div_hi_const", HI, 32'hFFFFFFFF);
    applyStimulus(3'd4, 32'd7, 32'd2, 0);
    checkOutput("divu_lo_const", LO, 32'd3);
    checkOutput("divu_hi_const", HI, 32'd1);
    applyStimulus(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    checkOutput("divovf_lo_const", LO, 32'h80000000);
    checkOutput("divovf_hi_const", HI, 32'd0);

    writeHiLo(3'd5, 32'h1234);
    writeHiLo(3'd6, 32'h5678);
    applyStimulus(3'd4, 32'hDEADBEEF, 32'd0, 0);
    checkOutput("divz_hi_const", HI, 32'h1234);
    checkOutput("divz_lo_const", LO, 32'h5678);

    // Collision during MULT, then a back-to-back DIVU in the cycle busy falls.
    applyStimulus(3'd1, 32'd2, 32'd3, 2);
    checkOutput("coll_hi_const", HI, 32'd0);
    checkOutput("coll_lo_const", LO, 32'd6);
    applyStimulus(3'd4, 32'd9, 32'd4, 0);
    checkOutput("b2b_lo_const", LO, 32'd2);
    checkOutput("b2b_hi_const", HI, 32'd1);

    // Asynchronous reset mid-cycle, aborting a MULT in busy cycle 3.
    a = 32'd5; b = 32'd7; MDUOp = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_busy_c3", busy, 1'b1);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_hi", HI, 32'd0);
    checkOutput("async_lo", LO, 32'd0);
    checkOutput("async_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    modelHi = '0; modelLo = '0;
    for (int i = 0; i < MULT_N + 2; i++) begin
      @(negedge clk);
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_hi", HI, 32'd0);
      checkOutput("abort_lo", LO, 32'd0);
    end

    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(1, 6));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 5));
      if ($urandom_range(0, 5) == 0) x = 32'h80000000;
      if (op >= 3'd5) writeHiLo(op, x);
      else applyStimulus(op, x, y, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit sitting beside the ALU in the EX stage of the five-stage MIPS pipeline. It accepts one operation per start pulse, computes signed/unsigned 32×32 multiply or 32/32 divide over a fixed number of cycles, and commits the result into architectural HI/LO registers. The hazard unit stalls any instruction that touches HI/LO while `busy` or `start` is high. MTHI and MTLO write HI and LO directly.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT and MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV and DIVU.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state immediately.
- `a`  in  32  operand rs (dividend / multiplicand); also the MTHI/MTLO data.
- `b`  in  32  operand rt (divisor / multiplier).
- `MDUOp`  in  3  opcode: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
- `start`  in  1  one-cycle pulse; launches ops 1–4.
- `busy`  out  1  operation in flight.
- `HI`  out  32  architectural HI.
- `LO`  out  32  architectural LO.

## Operation
- State machine has two states, IDLE and RUN, plus a counter `cnt` wide enough for max(MULT_CYCLES, DIV_CYCLES).
- In IDLE, on a rising edge with `start`=1 and `MDUOp` in 1–4:
  - compute the result from `a`/`b` and latch it into pending registers `phi`/`plo`;
  - load `cnt` with the op's cycle count;
  - go to RUN.
  - Operands are sampled only at this edge. Later changes on `a`/`b` have no effect.
- In RUN:
  - `cnt` decrements each edge.
  - On the edge where `cnt`==1: HI←`phi`, LO←`plo`, return to IDLE.
- MULT: {HI,LO} = signed(a)×signed(b), full 64 bits.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV, signed:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient → LO, remainder → HI.
- Divide by zero (`b`=0, DIV or DIVU): the unit still runs the full DIV_CYCLES with `busy` high. HI and LO are left unchanged at commit.
- MTHI / MTLO:
  - take effect in IDLE on the edge where `MDUOp` is 5 or 6, regardless of `start`;
  - HI (or LO) ← `a`;
  - `busy` stays 0.
- While RUN, all inputs are ignored: a new `start`, MTHI, or MTLO is dropped. The hazard unit guarantees none arrive.
- `start` with `MDUOp` of 0, 5, 6 or 7 does not enter RUN.
- Reset (`reset`=0), asynchronous: HI=0, LO=0, `busy`=0, state=IDLE, `cnt`=0, `phi`=`plo`=0.
  - A reset mid-operation aborts it. The pending result is discarded and never committed.

## Timing
- Cycle 0: `start`=1 is sampled at the end of cycle 0.
- Cycles 1..N: `busy`=1, where N = MULT_CYCLES or DIV_CYCLES.
- The edge ending cycle N:
  - commits HI/LO;
  - `busy` falls, so it reads 0 in cycle N+1.
  - New HI/LO values are visible in cycle N+1.
- `busy` is registered: it is 0 in cycle 0 and goes high only after the sampling edge.
- Back-to-back operation: a `start` in cycle N+1 is accepted. A `start` in cycle N (while `busy`=1) is ignored.
- MTHI/MTLO: the new value is visible on HI/LO the cycle after the write edge.
- HI and LO are register outputs with no combinational path from the inputs.

## Test plan
- Reset: drive `reset`=0 asynchronously mid-cycle → HI=LO=0 and `busy`=0 before the next edge. Start MULT, then assert reset in busy cycle 3 → HI and LO stay 0 and `busy` stays 0 after release.
- MULT with a=0xFFFFFFFE (−2), b=3: `busy` high for exactly cycles 1–5; in cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with MULTU → HI=0x00000002, LO=0xFFFFFFFA.
- DIV with a=−7 (0xFFFFFFF9), b=2: `busy` high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with a=7, b=2 → LO=3, HI=1.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU by 0 after MTHI 0x1234 and MTLO 0x5678 → `busy` high for 10 cycles, then HI=0x1234, LO=0x5678 unchanged.
- Collision:
  - While busy with MULT 2×3, pulse `start` with DIV and drive MTHI 0xAAAA → both ignored; final HI=0, LO=6.
  - `start` DIVU 9/4 in the cycle right after `busy` falls → accepted; `busy` high for 10 cycles; then LO=2, HI=1.
